int_ctrl: RTL and testbench

Interrupt controller between the pipeline CPU and the interrupt sources, with the timer on source 0. It samples level-sensitive request lines, applies a per-source enable mask and a global enable, and picks one winner by fixed priority (lowest index wins). It holds a request to the pipeline until the pipeline takes the trap, then sends a one-cycle acknowledge pulse back to the winning source. It blocks further interrupts until the handler returns.

---
 rtl/int_ctrl.sv | 119 +++++++++++
 tb/tb_int_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// int_ctrl: fixed-priority interrupt controller (lowest index wins).
// Holds one request until the pipeline traps, acks it, blocks until eret.
module int_ctrl #(
  parameter int          NUM_SRC    = 4,
  parameter int          ID_W       = 2,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int          VEC_STRIDE = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic [NUM_SRC-1:0] irq_ack,
  input  logic               cfg_we,
  input  logic [NUM_SRC-1:0] cfg_mask,
  input  logic               cfg_gie,
  output logic               gie,
  output logic               int_req,
  output logic [ID_W-1:0]    int_id,
  output logic [31:0]        int_vector,
  input  logic               int_taken,
  input  logic               int_ret,
  output logic               in_service,
  output logic [31:0]        int_count
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pend;
  logic [ID_W-1:0]    win_id;
  logic [31:0]        win_vec;
  logic               fire;
  logic               take;
  logic               ret;

  assign pend       = irq_src & mask;
  assign int_req    = (state == REQ);
  assign in_service = (state == SERVICE);

  // Scan high to low so the lowest set index is the last one written.
  always_comb begin
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pend[i]) win_id = ID_W'(i);
    end
  end

  assign win_vec = VEC_BASE + 32'(win_id) * 32'(VEC_STRIDE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    fire     = 1'b0;
    take     = 1'b0;
    ret      = 1'b0;
    unique case (state)
      IDLE: begin
        if (gie && (|pend)) begin
          fire     = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        if (int_taken) begin
          take     = 1'b1;
          state_nx = SERVICE;
        end else if (!pend[int_id] || !gie) begin
          state_nx = IDLE;
        end
      end
      SERVICE: begin
        if (int_ret) begin
          ret      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Hardware gie updates are ordered after the config write so they win.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask       <= '0;
      gie        <= 1'b0;
      int_id     <= '0;
      int_vector <= VEC_BASE;
      irq_ack    <= '0;
      int_count  <= '0;
    end else begin
      irq_ack <= '0;
      if (cfg_we) begin
        mask <= cfg_mask;
        gie  <= cfg_gie;
      end
      if (fire) begin
        int_id     <= win_id;
        int_vector <= win_vec;
      end
      if (take) begin
        irq_ack   <= NUM_SRC'(1) << int_id;
        gie       <= 1'b0;
        int_count <= int_count + 32'd1;
      end
      if (ret) gie <= 1'b1;
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: scenario tasks for int_ctrl.
// Acks are checked against a queue of expected pulses.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  irq_src = '0;
  logic [3:0]  irq_ack;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_mask = '0;
  logic        cfg_gie = 1'b0;
  logic        gie;
  logic        int_req;
  logic [1:0]  int_id;
  logic [31:0] int_vector;
  logic        int_taken = 1'b0;
  logic        int_ret = 1'b0;
  logic        in_service;
  logic [31:0] int_count;

  typedef struct packed {
    logic [3:0]  ack;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] exp_count = '0;
  int          errors = 0;
  int          checks = 0;

  int_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .irq_src    (irq_src),
    .irq_ack    (irq_ack),
    .cfg_we     (cfg_we),
    .cfg_mask   (cfg_mask),
    .cfg_gie    (cfg_gie),
    .gie        (gie),
    .int_req    (int_req),
    .int_id     (int_id),
    .int_vector (int_vector),
    .int_taken  (int_taken),
    .int_ret    (int_ret),
    .in_service (in_service),
    .int_count  (int_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout req=%b svc=%b", int_req, in_service);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (irq_ack !== 4'b0000) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected got=%b want=none", irq_ack);
      end else begin
        e = sb.pop_front();
        if (irq_ack !== e.ack || int_count !== e.cnt) begin
          errors++;
          $display("FAIL ack_sb got=%b/%0h want=%b/%0h",
                   irq_ack, int_count, e.ack, e.cnt);
        end
      end
    end
  endtask

  task automatic cfg(input logic [3:0] m, input logic g);
    cfg_we   = 1'b1;
    cfg_mask = m;
    cfg_gie  = g;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic take(input int id);
    int_taken = 1'b1;
    exp_count = exp_count + 32'd1;
    sb.push_back('{ack: 4'(1 << id), cnt: exp_count});
    tick();
    int_taken = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({int_req, int_id, int_vector, irq_ack, in_service, int_count, gie}
        !== {1'b0, 2'd0, 32'h100, 4'b0, 1'b0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_vals req=%b id=%0d vec=%h ack=%b svc=%b cnt=%0d gie=%b",
               int_req, int_id, int_vector, irq_ack, in_service, int_count, gie);
    end
  endtask

  task automatic test_basic();
    cfg(4'b0001, 1'b1);
    irq_src = 4'b0001;
    tick();
    checks++;
    if ({int_req, int_id, int_vector} !== {1'b1, 2'd0, 32'h100}) begin
      errors++;
      $display("FAIL basic_req got=%b/%0d/%h want=1/0/100",
               int_req, int_id, int_vector);
    end
    tick();
    tick();
    take(0);
    checks++;
    if ({irq_ack, int_req, in_service, gie, int_count}
        !== {4'b0001, 1'b0, 1'b1, 1'b0, 32'd1}) begin
      errors++;
      $display("FAIL basic_take got ack=%b req=%b svc=%b gie=%b cnt=%0d want 0001/0/1/0/1",
               irq_ack, int_req, in_service, gie, int_count);
    end
    irq_src = 4'b0000;
    tick();
    checks++;
    if (irq_ack !== 4'b0000) begin
      errors++;
      $display("FAIL basic_ack_len got=%b want=0000", irq_ack);
    end
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
    checks++;
    if ({gie, in_service, int_req} !== 3'b100) begin
      errors++;
      $display("FAIL basic_ret got=%b want=100", {gie, in_service, int_req});
    end
  endtask

  task automatic test_priority();
    cfg(4'b1111, 1'b1);
    irq_src = 4'b1010;
    tick();
    checks++;
    if ({int_req, int_id, int_vector} !== {1'b1, 2'd1, 32'h104}) begin
      errors++;
      $display("FAIL prio_first got=%b/%0d/%h want=1/1/104",
               int_req, int_id, int_vector);
    end
    take(1);
    irq_src = 4'b1000;
    tick();
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
    checks++;
    if ({int_req, gie} !== 2'b01) begin
      errors++;
      $display("FAIL prio_gap got=%b want=01", {int_req, gie});
    end
    tick();
    checks++;
    if ({int_req, int_id, int_vector} !== {1'b1, 2'd3, 32'h10C}) begin
      errors++;
      $display("FAIL prio_second got=%b/%0d/%h want=1/3/10c",
               int_req, int_id, int_vector);
    end
    take(3);
    irq_src = 4'b0000;
    tick();
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
  endtask

  task automatic test_withdraw();
    cfg(4'b0100, 1'b1);
    irq_src = 4'b0100;
    tick();
    checks++;
    if ({int_req, int_id} !== {1'b1, 2'd2}) begin
      errors++;
      $display("FAIL wd_req got=%b/%0d want=1/2", int_req, int_id);
    end
    irq_src = 4'b0000;
    tick();
    checks++;
    if ({int_req, irq_ack, int_count} !== {1'b0, 4'b0, exp_count}) begin
      errors++;
      $display("FAIL wd_drop got=%b/%b/%0d want=0/0000/%0d",
               int_req, irq_ack, int_count, exp_count);
    end
    tick();
  endtask

  task automatic test_mask_gie();
    logic seen;
    cfg(4'b1111, 1'b0);
    irq_src = 4'b1111;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (int_req !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL gie_off got=req_seen want=no_req");
    end
    cfg_we   = 1'b1;
    cfg_mask = 4'b0100;
    cfg_gie  = 1'b1;
    tick();
    cfg_we   = 1'b0;
    checks++;
    if (int_req !== 1'b0) begin
      errors++;
      $display("FAIL gie_early got=%b want=0", int_req);
    end
    tick();
    checks++;
    if ({int_req, int_id, int_vector} !== {1'b1, 2'd2, 32'h108}) begin
      errors++;
      $display("FAIL gie_on got=%b/%0d/%h want=1/2/108",
               int_req, int_id, int_vector);
    end
  endtask

  task automatic test_boundaries();
    int_ret = 1'b1;
    take(2);
    int_ret = 1'b0;
    checks++;
    if ({in_service, int_req, gie, int_count}
        !== {1'b1, 1'b0, 1'b0, exp_count}) begin
      errors++;
      $display("FAIL both_in_req got=%b/%b/%b/%0d want=1/0/0/%0d",
               in_service, int_req, gie, int_count, exp_count);
    end
    int_taken = 1'b1;
    tick();
    int_taken = 1'b0;
    checks++;
    if ({in_service, gie, irq_ack, int_count}
        !== {1'b1, 1'b0, 4'b0, exp_count}) begin
      errors++;
      $display("FAIL taken_in_svc got=%b/%b/%b/%0d want=1/0/0000/%0d",
               in_service, gie, irq_ack, int_count, exp_count);
    end
    irq_src = 4'b0000;
    int_ret = 1'b1;
    tick();
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
    checks++;
    if ({in_service, int_req, gie} !== 3'b001) begin
      errors++;
      $display("FAIL ret_in_idle got=%b want=001", {in_service, int_req, gie});
    end
    force dut.int_count = 32'hFFFF_FFFF;
    tick();
    release dut.int_count;
    tick();
    exp_count = 32'hFFFF_FFFF;
    cfg(4'b0001, 1'b1);
    irq_src = 4'b0001;
    tick();
    take(0);
    checks++;
    if (int_count !== 32'd0) begin
      errors++;
      $display("FAIL count_wrap got=%h want=00000000", int_count);
    end
    irq_src = 4'b0000;
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic seen;
    cfg(4'b0010, 1'b1);
    irq_src = 4'b0010;
    tick();
    take(1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_count = '0;
    checks++;
    if ({int_req, int_id, int_vector, irq_ack, in_service, int_count, gie}
        !== {1'b0, 2'd0, 32'h100, 4'b0, 1'b0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_svc req=%b id=%0d vec=%h ack=%b svc=%b cnt=%0d gie=%b",
               int_req, int_id, int_vector, irq_ack, in_service, int_count, gie);
    end
    cfg(4'b0010, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({int_req, int_id, int_vector, irq_ack, in_service, int_count, gie}
        !== {1'b0, 2'd0, 32'h100, 4'b0, 1'b0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_req req=%b id=%0d vec=%h ack=%b svc=%b cnt=%0d gie=%b",
               int_req, int_id, int_vector, irq_ack, in_service, int_count, gie);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (int_req !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_noreq got=req_seen want=no_req");
    end
    cfg(4'b0010, 1'b1);
    tick();
    checks++;
    if ({int_req, int_id} !== {1'b1, 2'd1}) begin
      errors++;
      $display("FAIL reset_recfg got=%b/%0d want=1/1", int_req, int_id);
    end
    irq_src = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_withdraw();
    test_mask_gie();
    test_boundaries();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL ack_missing got=%0d pending want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
